receiver_uart_num: RTL and testbench

//  RX-side counterpart of the ASCII number sender. Pops bytes from the UART RX FIFO and

---
 rtl/receiver_uart_num.sv | 107 ++++++++++
 tb/tb_receiver_uart_num.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_uart_num.sv
// Parses a CR/LF-terminated decimal ASCII line from the RX FIFO into a binary value; define RXNUM_BACKSPACE_EN for BS editing.
// Latency: terminator at FIFO head -> pop next cycle -> o_valid/o_error the cycle after; one byte per 2 cycles.
// Backpressure: waits while empty is high; the byte under a pop pulse was latched earlier, so empty is ignored then.
module receiver_uart_num #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [7:0]       rx_data,
    output logic             pop,
    output logic [VAL_W-1:0] o_value,
    output logic             o_valid,
    output logic             o_error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {FETCH, PARSE, DISCARD} state_t;

    state_t             state;
    logic [7:0]         byte_reg;
    logic [VAL_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               drop;
    logic               is_digit;
    logic               is_term;
    logic               cnt_full;

    assign is_digit = (byte_reg >= 8'h30) && (byte_reg <= 8'h39);
    assign is_term  = (byte_reg == 8'h0D) || (byte_reg == 8'h0A);
    assign cnt_full = (cnt == CNT_W'(MAX_DIGITS));

`ifdef RXNUM_BACKSPACE_EN
    logic is_bs;
    assign is_bs = (byte_reg == 8'h08);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pop      <= 1'b0;
            o_valid  <= 1'b0;
            o_error  <= 1'b0;
            o_value  <= '0;
            acc      <= '0;
            cnt      <= '0;
            byte_reg <= '0;
            drop     <= 1'b0;
        end else begin
            pop     <= 1'b0;
            o_valid <= 1'b0;
            o_error <= 1'b0;
            case (state)
                FETCH, DISCARD: begin
                    // DISCARD fetches exactly like FETCH; drop marks the byte as part of a rejected line
                    if (!empty) begin
                        byte_reg <= rx_data;
                        pop      <= 1'b1;
                        drop     <= (state == DISCARD);
                        state    <= PARSE;
                    end
                end
                PARSE: begin
                    if (drop) begin
                        state <= is_term ? FETCH : DISCARD;
                    end else if (is_digit) begin
                        if (cnt_full) begin
                            o_error <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= DISCARD;
                        end else begin
                            acc   <= acc * VAL_W'(10) + VAL_W'(byte_reg[3:0]);
                            cnt   <= cnt + CNT_W'(1);
                            state <= FETCH;
                        end
                    end else if (is_term) begin
                        if (cnt != '0) begin
                            o_value <= acc;
                            o_valid <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                        end
                        state <= FETCH;
`ifdef RXNUM_BACKSPACE_EN
                    end else if (is_bs) begin
                        if (cnt != '0) begin
                            acc <= acc / VAL_W'(10);
                            cnt <= cnt - CNT_W'(1);
                        end
                        state <= FETCH;
`endif
                    end else begin
                        o_error <= 1'b1;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= DISCARD;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_uart_num.sv
// Bench for receiver_uart_num: fixed line table plus random lines against a digit-list reference model.
module tb_receiver_uart_num;

    localparam int MAXD = 4;
    localparam int VW   = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          pop;
    logic [VW-1:0] o_value;
    logic          o_valid;
    logic          o_error;

    receiver_uart_num #(.MAX_DIGITS(MAXD), .VAL_W(VW)) dut (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .rx_data (rx_data),
        .pop     (pop),
        .o_value (o_value),
        .o_valid (o_valid),
        .o_error (o_error)
    );

    always #5 clk = ~clk;

    byte unsigned fifo_q[$];
    int  ev_q[$];
    int  exp_q[$];
    int  pop_cnt   = 0;
    int  underflow = 0;
    int  both_hi   = 0;
    bit  gap_en    = 1'b0;
    int  n_checks  = 0;
    int  n_fail    = 0;

    // reference model state: pending digits, discard mode, last reported value
    int  m_dig[$];
    bit  m_drop = 1'b0;
    int  m_last = 0;

    typedef struct {
        string s;
        int    nv;
        int    ne;
        int    val;
        int    pops;
    } vec_t;

    // FIFO model and output monitor, both away from the active edge
    always @(negedge clk) begin
        if (o_valid) ev_q.push_back(int'(o_value));
        if (o_error) ev_q.push_back(-1);
        if (o_valid && o_error) both_hi++;
        if (pop) begin
            pop_cnt++;
            if (fifo_q.size() == 0) underflow++;
            else void'(fifo_q.pop_front());
        end
        if (fifo_q.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            empty   = 1'b0;
            rx_data = fifo_q[0];
        end else begin
            empty   = 1'b1;
            rx_data = 8'($urandom);
        end
    end

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_err();
        exp_q.push_back(-1);
        m_dig.delete();
        m_drop = 1'b1;
    endfunction

    function automatic void model_byte(byte unsigned b);
        bit term;
        int v;
        term = (b == 8'h0D) || (b == 8'h0A);
        if (m_drop) begin
            if (term) m_drop = 1'b0;
        end else if (b >= 8'h30 && b <= 8'h39) begin
            if (m_dig.size() < MAXD) m_dig.push_back(int'(b) - 48);
            else model_err();
        end else if (term) begin
            if (m_dig.size() > 0) begin
                v = 0;
                foreach (m_dig[i]) v = v * 10 + m_dig[i];
                exp_q.push_back(v);
                m_last = v;
                m_dig.delete();
            end
`ifdef RXNUM_BACKSPACE_EN
        end else if (b == 8'h08) begin
            if (m_dig.size() > 0) void'(m_dig.pop_back());
`endif
        end else begin
            model_err();
        end
    endfunction

    task automatic run_bytes(input byte unsigned q[$], output int nv, output int ne, output int pc);
        int cyc;
        pop_cnt = 0;
        ev_q.delete();
        exp_q.delete();
        foreach (q[i]) begin
            fifo_q.push_back(q[i]);
            model_byte(q[i]);
        end
        cyc = 0;
        while (fifo_q.size() != 0 && cyc < 40 * q.size() + 200) begin
            @(posedge clk);
            cyc++;
        end
        if (fifo_q.size() != 0) begin
            check("drain_timeout", fifo_q.size(), 0);
            fifo_q.delete();
        end
        repeat (4) @(posedge clk);
        #2;
        check("event_count", ev_q.size(), exp_q.size());
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
            check("event_value", ev_q[i], exp_q[i]);
        check("o_value_model", int'(o_value), m_last);
        nv = 0;
        ne = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i] < 0) ne++;
            else nv++;
        end
        pc = pop_cnt;
    endtask

    task automatic run_line(input string s, output int nv, output int ne, output int pc);
        byte unsigned q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        run_bytes(q, nv, ne, pc);
    endtask

    initial begin
        vec_t tbl[6];
        int   nv, ne, pc, len, r;
        byte unsigned q[$];

        tbl[0] = '{"1234\015",          1, 0, 1234, 5};
        tbl[1] = '{"0\015\0129999\012", 2, 0, 9999, 8};
        tbl[2] = '{"12a4\0157\012",     1, 1, 7,    7};
        tbl[3] = '{"12345\015",         0, 1, 7,    6};
        tbl[4] = '{"3\015",             1, 0, 3,    2};
`ifdef RXNUM_BACKSPACE_EN
        tbl[5] = '{"123\0104\015",      1, 0, 124,  6};
`else
        tbl[5] = '{"123\0104\015",      0, 1, 3,    6};
`endif

        repeat (3) @(posedge clk);
        #2;
        check("reset_pop", int'(pop), 0);
        check("reset_valid", int'(o_valid), 0);
        check("reset_error", int'(o_error), 0);
        check("reset_value", int'(o_value), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            gap_en = (pass == 1);
            for (int i = 0; i < 6; i++) begin
                run_line(tbl[i].s, nv, ne, pc);
                check($sformatf("tbl%0d_valid", i), nv, tbl[i].nv);
                check($sformatf("tbl%0d_error", i), ne, tbl[i].ne);
                check($sformatf("tbl%0d_value", i), int'(o_value), tbl[i].val);
                check($sformatf("tbl%0d_pops", i), pc, tbl[i].pops);
            end
        end

        // partial line lost across a reset pulse
        run_line("12", nv, ne, pc);
        check("partial_events", nv + ne, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pop", int'(pop), 0);
        check("midrst_value", int'(o_value), 0);
        repeat (2) @(posedge clk);
        #2;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_error", int'(o_error), 0);
        m_dig.delete();
        m_drop = 1'b0;
        m_last = 0;
        @(negedge clk);
        rst = 1'b0;
        run_line("3\015", nv, ne, pc);
        check("after_rst_valid", nv, 1);
        check("after_rst_value", int'(o_value), 3);

        // random lines with random FIFO gaps
        gap_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            q.delete();
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 19);
                if (r < 15)       q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                else if (r == 15) q.push_back(8'h78);
                else if (r == 16) q.push_back(8'h08);
                else if (r == 17) q.push_back(8'h0D);
                else if (r == 18) q.push_back(8'h0A);
                else              q.push_back(8'h20);
            end
            q.push_back(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
            run_bytes(q, nv, ne, pc);
            check("rand_pops", pc, q.size());
        end

        check("pop_underflow", underflow, 0);
        check("valid_error_overlap", both_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
